morse_rx: RTL and testbench

MORSE_RX -- requirements
Module: morse_rx

---
 rtl/morse_rx.sv | 148 ++++++++++++++
 tb/tb_morse_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx.sv
// morse_rx: Morse element receiver.
//   Classifies each mark on the serial line as a dot or a dash by counting
//   its length in clock cycles, collects up to five elements per symbol and
//   reports the symbol once the line has been low for 2*UNIT samples.
//
// Ports
//   clk    in   single clock, rising-edge
//   reset  in   asynchronous active-high reset
//   in     in   serial line, 1 = mark, 0 = space
//   code   out  element pattern, bit i = element i (0 dot, 1 dash)
//   len    out  number of valid elements in code (1..5)
//   valid  out  one-cycle pulse: code/len carry a new symbol
//   error  out  one-cycle pulse: symbol with more than five elements dropped
//
// state | meaning
// IDLE  | no elements collected, line low
// MARK  | line high, counting mark length
// GAP   | line low after a mark, counting gap length
module morse_rx #(
   parameter int UNIT = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic [4:0] code,
   output logic [2:0] len,
   output logic       valid,
   output logic       error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [15:0] TWO_UNIT = 16'(2 * UNIT);
   localparam logic [15:0] END_CNT  = 16'(2 * UNIT - 1);
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [4:0]  store_q, store_d;
   logic [2:0]  len_int_q, len_int_d;
   logic        ovf_q, ovf_d;
   logic [4:0]  code_q, code_d;
   logic [2:0]  len_q, len_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         store_q   <= '0;
         len_int_q <= '0;
         ovf_q     <= 1'b0;
         code_q    <= '0;
         len_q     <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         store_q   <= store_d;
         len_int_q <= len_int_d;
         ovf_q     <= ovf_d;
         code_q    <= code_d;
         len_q     <= len_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      store_d   = store_q;
      len_int_d = len_int_q;
      ovf_d     = ovf_q;
      code_d    = code_q;
      len_d     = len_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (in) begin
               state_d = MARK;
               count_d = 16'd1;
            end
         end

         MARK: begin
            if (in) begin
               if (count_q != CNT_MAX) begin
                  count_d = count_q + 16'd1;
               end
            end else begin
               // A sixth element only marks the symbol as overflowed; the
               // store keeps the first five untouched.
               if (len_int_q == 3'd5) begin
                  ovf_d = 1'b1;
               end else begin
                  store_d[len_int_q] = (count_q >= TWO_UNIT);
                  len_int_d          = len_int_q + 3'd1;
               end
               state_d = GAP;
               count_d = 16'd1;
            end
         end

         GAP: begin
            if (in) begin
               state_d = MARK;
               count_d = 16'd1;
            end else if (count_q < END_CNT) begin
               count_d = count_q + 16'd1;
            end else begin
               // The first low sample was counted on entry to GAP, so this
               // is the 2*UNIT-th consecutive low: the symbol is complete.
               if (ovf_q) begin
                  error_d = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  code_d  = store_q;
                  len_d   = len_int_q;
               end
               store_d   = '0;
               len_int_d = '0;
               ovf_d     = 1'b0;
               count_d   = '0;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign code  = code_q;
   assign len   = len_q;
   assign valid = valid_q;
   assign error = error_q;

endmodule

// File: tb/tb_morse_rx.sv
module tb_morse_rx;

   localparam int UNIT = 2;

   logic       clk;
   logic       reset;
   logic       din;
   logic [4:0] code;
   logic [2:0] len;
   logic       valid;
   logic       error;

   int checks   = 0;
   int failures = 0;

   morse_rx #(.UNIT(UNIT)) dut (
      .clk   (clk),
      .reset (reset),
      .in    (din),
      .code  (code),
      .len   (len),
      .valid (valid),
      .error (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: works on run lengths of the line and a queue of
   // received elements, producing the outputs expected after each edge.
   bit         elems[$];
   bit         mark_active;
   int         mark_len;
   int         low_run;
   logic       exp_valid;
   logic       exp_err;
   logic [4:0] exp_code;
   logic [2:0] exp_len;

   int         n_valid;
   int         n_err;

   task automatic model_reset();
      elems.delete();
      mark_active = 0;
      mark_len    = 0;
      low_run     = 0;
      exp_valid   = 1'b0;
      exp_err     = 1'b0;
      exp_code    = '0;
      exp_len     = '0;
   endtask

   task automatic model_step(input bit x);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (x) begin
         if (!mark_active) begin
            mark_active = 1;
            mark_len    = 0;
         end
         mark_len++;
         low_run = 0;
      end else begin
         if (mark_active) begin
            elems.push_back(mark_len >= 2 * UNIT);
            mark_active = 0;
            low_run     = 1;
         end else if (elems.size() > 0) begin
            low_run++;
         end
         if (elems.size() > 0 && low_run == 2 * UNIT) begin
            if (elems.size() > 5) begin
               exp_err = 1'b1;
            end else begin
               exp_valid = 1'b1;
               exp_code  = '0;
               foreach (elems[i]) exp_code[i] = elems[i];
               exp_len   = 3'(elems.size());
            end
            elems.delete();
            low_run = 0;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: drive the sample, advance, compare against the model.
   task automatic cycle(input bit x);
      din = x;
      model_step(x);
      @(posedge clk);
      #1;
      check("cycle_outputs", {22'd0, valid, error, code, len},
            {22'd0, exp_valid, exp_err, exp_code, exp_len});
      check("valid_error_exclusive", {31'd0, valid & error}, 32'd0);
      if (valid) n_valid++;
      if (error) n_err++;
   endtask

   typedef struct {
      int         n;
      int         hi[6];
      int         lo[6];
      logic [4:0] code;
      logic [2:0] len;
      bit         err;
   } vec_t;

   vec_t vecs[7];

   task automatic apply_vec(input int k);
      int nv;
      int ne;
      nv = n_valid;
      ne = n_err;
      for (int i = 0; i < vecs[k].n; i++) begin
         repeat (vecs[k].hi[i]) cycle(1'b1);
         repeat (vecs[k].lo[i]) cycle(1'b0);
      end
      check($sformatf("vec%0d_valid_pulses", k), 32'(n_valid - nv), vecs[k].err ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_error_pulses", k), 32'(n_err - ne), vecs[k].err ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_code", k), {27'd0, code}, {27'd0, vecs[k].code});
      check($sformatf("vec%0d_len", k), {29'd0, len}, {29'd0, vecs[k].len});
   endtask

   initial begin
      // E; N with a 2-cycle intra gap; A; dot/dash boundary (3 vs 4 high);
      // five dashes; six dots (error, keeps 11111/5); five dots.
      vecs[0] = '{1, '{2,0,0,0,0,0}, '{4,0,0,0,0,0}, 5'b00000, 3'd1, 1'b0};
      vecs[1] = '{2, '{6,2,0,0,0,0}, '{2,4,0,0,0,0}, 5'b00001, 3'd2, 1'b0};
      vecs[2] = '{2, '{1,5,0,0,0,0}, '{3,6,0,0,0,0}, 5'b00010, 3'd2, 1'b0};
      vecs[3] = '{2, '{3,4,0,0,0,0}, '{1,4,0,0,0,0}, 5'b00010, 3'd2, 1'b0};
      vecs[4] = '{5, '{4,4,4,4,9,0}, '{1,2,3,1,5,0}, 5'b11111, 3'd5, 1'b0};
      vecs[5] = '{6, '{1,1,1,1,1,1}, '{2,2,2,2,2,4}, 5'b11111, 3'd5, 1'b1};
      vecs[6] = '{5, '{1,2,3,1,2,0}, '{3,3,3,3,4,0}, 5'b00000, 3'd5, 1'b0};

      n_valid = 0;
      n_err   = 0;
      model_reset();
      reset = 1'b1;
      din   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {22'd0, valid, error, code, len}, 32'd0);
      reset = 1'b0;

      repeat (20) cycle(1'b0);
      check("idle_no_valid", 32'(n_valid), 32'd0);
      check("idle_no_error", 32'(n_err), 32'd0);

      for (int k = 0; k < 7; k++) apply_vec(k);

      // Asynchronous reset during the second mark of a symbol.
      apply_vec(1);
      repeat (2) cycle(1'b1);
      repeat (2) cycle(1'b0);
      cycle(1'b1);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_immediate", {22'd0, valid, error, code, len}, 32'd0);
      model_reset();
      din = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      begin
         int nv;
         int ne;
         nv = n_valid;
         ne = n_err;
         repeat (6) cycle(1'b0);
         check("post_reset_no_valid", 32'(n_valid - nv), 32'd0);
         check("post_reset_no_error", 32'(n_err - ne), 32'd0);
         repeat (2) cycle(1'b1);
         repeat (4) cycle(1'b0);
         check("post_reset_valid", 32'(n_valid - nv), 32'd1);
         check("post_reset_code", {27'd0, code}, 32'd0);
         check("post_reset_len", {29'd0, len}, 32'd1);
      end

      // Randomized symbols, including ones with more than five elements.
      for (int s = 0; s < 150; s++) begin
         int ne_s;
         ne_s = $urandom_range(1, 7);
         for (int e = 0; e < ne_s; e++) begin
            repeat ($urandom_range(1, 6)) cycle(1'b1);
            if (e < ne_s - 1) repeat ($urandom_range(1, 3)) cycle(1'b0);
         end
         repeat ($urandom_range(4, 7)) cycle(1'b0);
      end

      // Unstructured random line activity.
      for (int c = 0; c < 1500; c++) cycle(($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1 ^ ($urandom_range(0, 1) == 1));
      repeat (8) cycle(1'b0);

      // Mark long enough to saturate the sample counter.
      begin
         int nv;
         nv = n_valid;
         repeat (70000) cycle(1'b1);
         check("long_mark_no_pulse", 32'(n_valid - nv), 32'd0);
         repeat (4) cycle(1'b0);
         check("long_mark_valid", 32'(n_valid - nv), 32'd1);
         check("long_mark_code", {27'd0, code}, 32'd1);
         check("long_mark_len", {29'd0, len}, 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
